device_sync_hub: RTL and testbench

Memory-mapped device block on the cluster's device bus, the next generation of the top-level output/mutex logic. Provides a 16-bit output port and a parametrised bank of hardware mutexes. Adds per-mutex waiter tracking with round-robin ownership handoff on release, so contending cores are served fairly without re-polling acquire.

---
 rtl/device_sync_pkg.sv | 24 ++
 rtl/device_sync_hub_if.sv | 27 ++
 rtl/mutex_slot.sv | 78 +++++++
 rtl/device_sync_hub.sv | 58 +++++
 tb/tb_device_sync_hub.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/device_sync_pkg.sv
// Shared constants, address map and per-mutex state layout for the device sync hub.
package device_sync_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] OUTPUT_ADDR     = 10'h3ff;
    localparam logic [ADDR_W-1:0] MUTEX_BASE_ADDR = 10'h3fe;

    // Struct fields are sized for the largest supported core count; unused upper bits stay zero.
    localparam int MAX_CORES = 32;
    localparam int MAX_ID_W  = 5;

    typedef struct packed {
        logic                 held;
        logic [MAX_ID_W-1:0]  holder;
        logic [MAX_CORES-1:0] waiters;
    } mutex_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/device_sync_hub_if.sv
// Device bus between the cluster (master) and the sync hub (slave).
interface device_sync_hub_if
    import device_sync_pkg::*;
#(
  parameter int NUM_CORES = 8
);
  localparam int CID_W = id_width(NUM_CORES);

  logic [CID_W-1:0]  device_core_id;
  logic              device_write_en;
  logic              device_read_en;
  logic [ADDR_W-1:0] device_addr;
  logic [DATA_W-1:0] device_data_out;
  logic [DATA_W-1:0] device_data_in;
  logic [DATA_W-1:0] output_val;
  logic              output_enable;

  modport master (
    output device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
    input  device_data_in, output_val, output_enable
  );

  modport slave (
    input  device_core_id, device_write_en, device_read_en, device_addr, device_data_out,
    output device_data_in, output_val, output_enable
  );
endinterface

// File: rtl/mutex_slot.sv
// One hardware mutex: held/holder/waiters state and round-robin handoff on release.
// The picker scans upward from holder+1 so every waiter is served within NUM_CORES releases.
module mutex_slot
  import device_sync_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int CID_W     = id_width(NUM_CORES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic             acquire,
  input  logic [CID_W-1:0] req_id,
  output logic             mine
);

  mutex_state_t        st;
  mutex_state_t        st_nxt;
  logic [MAX_ID_W-1:0] id_ext;
  logic [MAX_ID_W-1:0] pick;
  logic [MAX_ID_W-1:0] cand;
  logic                found;
  logic                is_holder;
  int                  idx;

  assign id_ext    = MAX_ID_W'(req_id);
  assign is_holder = st.held && (st.holder == id_ext);
  assign mine      = is_holder;

  always_comb begin
    pick  = st.holder;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int off = 1; off <= NUM_CORES; off++) begin
      idx = int'(st.holder) + off;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      cand = idx[MAX_ID_W-1:0];
      if (!found && st.waiters[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    if (wr) begin
      if (acquire) begin
        if (!st.held) begin
          st_nxt.held   = 1'b1;
          st_nxt.holder = id_ext;
        end else if (st.holder != id_ext) begin
          st_nxt.waiters[id_ext] = 1'b1;
        end
      end else if (is_holder) begin
        if (st.waiters == '0) begin
          st_nxt.held = 1'b0;
        end else begin
          st_nxt.holder        = pick;
          st_nxt.waiters[pick] = 1'b0;
        end
      end else begin
        // A release from a non-holder withdraws its own queued request.
        st_nxt.waiters[id_ext] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= '0;
    end else begin
      st <= st_nxt;
    end
  end

endmodule

// File: rtl/device_sync_hub.sv
// Device-bus block: 16-bit output port plus a bank of round-robin hardware mutexes.
// Reads return registered data one cycle after read_en; writes take effect on the same edge.
module device_sync_hub
  import device_sync_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int NUM_MUTEX = 4
) (
  input logic               clk,
  input logic               reset_n,
  device_sync_hub_if.slave  bus
);

  logic                 id_ok;
  logic                 is_out;
  logic                 acquire;
  logic                 rd_bit;
  logic [NUM_MUTEX-1:0] hit;
  logic [NUM_MUTEX-1:0] mine;

  assign id_ok   = int'(bus.device_core_id) < NUM_CORES;
  assign is_out  = (bus.device_addr == OUTPUT_ADDR);
  assign acquire = (bus.device_data_out != '0);
  assign rd_bit  = id_ok && ((hit & mine) != '0);

  for (genvar i = 0; i < NUM_MUTEX; i++) begin : g_slot
    localparam logic [ADDR_W-1:0] SLOT_ADDR = MUTEX_BASE_ADDR - ADDR_W'(i);

    assign hit[i] = (bus.device_addr == SLOT_ADDR);

    mutex_slot #(.NUM_CORES(NUM_CORES)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (bus.device_write_en && hit[i] && id_ok),
      .acquire (acquire),
      .req_id  (bus.device_core_id),
      .mine    (mine[i])
    );
  end

  // A combined read+write performs the write and leaves read data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.device_data_in <= '0;
      bus.output_val     <= '0;
      bus.output_enable  <= 1'b0;
    end else begin
      bus.output_enable <= bus.device_write_en && is_out;
      if (bus.device_write_en && is_out) begin
        bus.output_val <= bus.device_data_out;
      end
      if (bus.device_read_en && !bus.device_write_en) begin
        bus.device_data_in <= {{(DATA_W-1){1'b0}}, rd_bit};
      end
    end
  end

endmodule

// File: tb/tb_device_sync_hub.sv
// Directed self-checking bench for device_sync_hub: output port, mutex acquire/release, handoff and reset.
module tb_device_sync_hub;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;
  logic [15:0] rd;

  device_sync_hub_if #(.NUM_CORES(8)) bus ();

  device_sync_hub #(.NUM_CORES(8), .NUM_MUTEX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.device_core_id  = '0;
    bus.device_write_en = 1'b0;
    bus.device_read_en  = 1'b0;
    bus.device_addr     = '0;
    bus.device_data_out = '0;
  endtask

  task automatic do_write(input logic [2:0] id, input logic [9:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.device_core_id  = id;
    bus.device_addr     = addr;
    bus.device_data_out = data;
    bus.device_write_en = 1'b1;
    @(negedge clk);
    bus.device_write_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] id, input logic [9:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus.device_core_id = id;
    bus.device_addr    = addr;
    bus.device_read_en = 1'b1;
    @(negedge clk);
    bus.device_read_en = 1'b0;
    data = bus.device_data_in;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    #12;
    tests_run++;
    if (bus.device_data_in !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_data_in got %h want 0000", bus.device_data_in);
    end
    tests_run++;
    if (bus.output_val !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_output_val got %h want 0000", bus.output_val);
    end
    tests_run++;
    if (bus.output_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_output_enable got %b want 0", bus.output_enable);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_output();
    do_write(3'd0, 10'h3ff, 16'h1234);
    tests_run++;
    if (bus.output_val !== 16'h1234) begin
      tests_failed++;
      $display("FAIL out_val got %h want 1234", bus.output_val);
    end
    tests_run++;
    if (bus.output_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL out_en_pulse got %b want 1", bus.output_enable);
    end
    @(negedge clk);
    tests_run++;
    if (bus.output_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL out_en_drop got %b want 0", bus.output_enable);
    end
    tests_run++;
    if (bus.output_val !== 16'h1234) begin
      tests_failed++;
      $display("FAIL out_val_hold got %h want 1234", bus.output_val);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.device_core_id  = 3'd1;
    bus.device_addr     = 10'h3ff;
    bus.device_data_out = 16'hAAAA;
    bus.device_write_en = 1'b1;
    @(negedge clk);
    bus.device_data_out = 16'h5555;
    tests_run++;
    if (bus.output_enable !== 1'b1 || bus.output_val !== 16'hAAAA) begin
      tests_failed++;
      $display("FAIL b2b_first got en=%b val=%h want en=1 val=aaaa", bus.output_enable, bus.output_val);
    end
    @(negedge clk);
    bus.device_write_en = 1'b0;
    tests_run++;
    if (bus.output_enable !== 1'b1 || bus.output_val !== 16'h5555) begin
      tests_failed++;
      $display("FAIL b2b_second got en=%b val=%h want en=1 val=5555", bus.output_enable, bus.output_val);
    end
    @(negedge clk);
    tests_run++;
    if (bus.output_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end got en=%b want 0", bus.output_enable);
    end
  endtask

  task automatic test_basic_mutex();
    do_write(3'd2, 10'h3fe, 16'h0001);
    do_read(3'd2, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL basic_owner_read got %h want 0001", rd);
    end
    // Combined write+read to an unmapped address: read data must hold at 1.
    @(negedge clk);
    bus.device_core_id  = 3'd2;
    bus.device_addr     = 10'h100;
    bus.device_data_out = 16'h0;
    bus.device_write_en = 1'b1;
    bus.device_read_en  = 1'b1;
    @(negedge clk);
    bus.device_write_en = 1'b0;
    bus.device_read_en  = 1'b0;
    tests_run++;
    if (bus.device_data_in !== 16'h0001) begin
      tests_failed++;
      $display("FAIL rw_hold got %h want 0001", bus.device_data_in);
    end
    do_read(3'd3, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL basic_other_read got %h want 0000", rd);
    end
    do_write(3'd2, 10'h3fe, 16'h0000);
    do_read(3'd2, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL basic_release_read got %h want 0000", rd);
    end
  endtask

  task automatic test_handoff();
    do_write(3'd1, 10'h3fe, 16'h0001);
    do_write(3'd5, 10'h3fe, 16'h0001);
    do_write(3'd3, 10'h3fe, 16'h00ff);
    do_read(3'd5, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL handoff_waiter_not_owner got %h want 0000", rd);
    end
    do_write(3'd1, 10'h3fe, 16'h0000);
    do_read(3'd3, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL handoff_to_3 got %h want 0001", rd);
    end
    do_read(3'd1, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL handoff_old_owner got %h want 0000", rd);
    end
    do_write(3'd3, 10'h3fe, 16'h0000);
    do_read(3'd5, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL handoff_to_5 got %h want 0001", rd);
    end
    do_write(3'd5, 10'h3fe, 16'h0000);
    do_read(3'd5, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL handoff_final_release got %h want 0000", rd);
    end
    do_write(3'd0, 10'h3fe, 16'h0001);
    do_read(3'd0, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL handoff_free_after got %h want 0001", rd);
    end
    do_write(3'd0, 10'h3fe, 16'h0000);
  endtask

  task automatic test_rr_wrap();
    do_write(3'd6, 10'h3fd, 16'h0001);
    do_write(3'd0, 10'h3fd, 16'h0001);
    do_write(3'd7, 10'h3fd, 16'h0001);
    do_write(3'd6, 10'h3fd, 16'h0000);
    do_read(3'd7, 10'h3fd, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL wrap_to_7 got %h want 0001", rd);
    end
    do_write(3'd7, 10'h3fd, 16'h0000);
    do_read(3'd0, 10'h3fd, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL wrap_to_0 got %h want 0001", rd);
    end
    do_write(3'd0, 10'h3fd, 16'h0000);
  endtask

  task automatic test_cancel();
    do_write(3'd1, 10'h3fc, 16'h0001);
    do_write(3'd4, 10'h3fc, 16'h0001);
    do_write(3'd4, 10'h3fc, 16'h0000);
    do_read(3'd1, 10'h3fc, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL cancel_owner_kept got %h want 0001", rd);
    end
    do_write(3'd1, 10'h3fc, 16'h0000);
    do_read(3'd4, 10'h3fc, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL cancel_no_handoff got %h want 0000", rd);
    end
    do_write(3'd2, 10'h3fc, 16'h0001);
    do_read(3'd2, 10'h3fc, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL cancel_mutex_free got %h want 0001", rd);
    end
    do_write(3'd2, 10'h3fc, 16'h0000);
  endtask

  task automatic test_independence_reset();
    logic [2:0] owner [4];
    owner[0] = 3'd1;
    owner[1] = 3'd3;
    owner[2] = 3'd5;
    owner[3] = 3'd6;
    for (int i = 0; i < 4; i++) begin
      do_write(owner[i], 10'h3fe - 10'(i), 16'h0001);
    end
    do_write(3'd7, 10'h3fe, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      do_read(owner[i], 10'h3fe - 10'(i), rd);
      tests_run++;
      if (rd !== 16'h0001) begin
        tests_failed++;
        $display("FAIL indep_hold_%0d got %h want 0001", i, rd);
      end
    end
    do_read(owner[1], 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL indep_cross got %h want 0000", rd);
    end
    do_read(owner[3], 10'h3fb, rd);
    do_read(owner[3], 10'h100, rd);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL unmapped_read got %h want 0000", rd);
    end
    do_read(owner[3], 10'h3fb, rd);
    do_write(3'd0, 10'h3ff, 16'hbeef);
    // Reset lands mid-cycle, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.device_data_in !== 16'h0 || bus.output_val !== 16'h0) begin
      tests_failed++;
      $display("FAIL async_reset got data_in=%h out=%h want 0000 0000", bus.device_data_in, bus.output_val);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(owner[i], 10'h3fe - 10'(i), rd);
      tests_run++;
      if (rd !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_cleared_%0d got %h want 0000", i, rd);
      end
    end
    // A surviving waiter for core 7 would capture the mutex on core 1's release.
    do_write(3'd1, 10'h3fe, 16'h0001);
    do_write(3'd1, 10'h3fe, 16'h0000);
    do_write(3'd2, 10'h3fe, 16'h0001);
    do_read(3'd2, 10'h3fe, rd);
    tests_run++;
    if (rd !== 16'h0001) begin
      tests_failed++;
      $display("FAIL reset_waiters_dropped got %h want 0001", rd);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_output();
    test_back_to_back();
    test_basic_mutex();
    test_handoff();
    test_rr_wrap();
    test_cancel();
    test_independence_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
